multi_clock_divider: RTL and testbench

//  NUM_CH independent clock dividers with runtime-programmable divisors.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/div_channel.sv | 77 +++++++
 rtl/multi_clock_divider.sv | 44 ++++
 tb/tb_multi_clock_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-timebase dividers.
// Default divisor width and reset divisor used by every channel.
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH = 18;
  localparam int CLK_DIV_RESET = 250000;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One programmable divider channel: tick enable plus 50%-duty clk_out.
// Divisor changes go through a shadow register and are committed glitch-free.
module div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV = CLK_DIV_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  input  logic             wr_now,
  output logic             tick,
  output logic             clk_out,
  output logic             upd_pending
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_shd;
  logic [WIDTH-1:0] last_cnt;
  logic             div_zero;
  logic             tc;

  always_comb begin
    div_zero = (div_act == '0);
    last_cnt = div_zero ? '0 : div_act - WIDTH'(1);
    tc       = !div_zero && (count == last_cnt);
  end

  // NOTE: the shadow divisor is reset too, so a pending update can never
  // survive rst and commit a stale value afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      div_act     <= WIDTH'(DEFAULT_DIV);
      div_shd     <= WIDTH'(DEFAULT_DIV);
      upd_pending <= 1'b0;
      tick        <= 1'b0;
      clk_out     <= 1'b0;
    end else if (sync_clr) begin
      count       <= '0;
      tick        <= 1'b0;
      clk_out     <= 1'b0;
      upd_pending <= 1'b0;
      if (wr) begin
        div_act <= wr_div;
        div_shd <= wr_div;
      end else if (upd_pending) begin
        div_act <= div_shd;
      end
    end else if (wr && wr_now) begin
      // Immediate restart: the write cycle never counts as terminal.
      div_act     <= wr_div;
      count       <= '0;
      upd_pending <= 1'b0;
      tick        <= 1'b0;
    end else begin
      tick  <= tc;
      count <= (tc || div_zero) ? '0 : count + WIDTH'(1);
      if (tc) begin
        clk_out <= ~clk_out;
      end
      // A deferred write masks any commit in its own cycle.
      if (wr) begin
        div_shd     <= wr_div;
        upd_pending <= 1'b1;
      end else if (upd_pending && (tc || div_zero)) begin
        div_act     <= div_shd;
        upd_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// Bank of NUM_CH independent programmable clock dividers.
// Decodes the shared write port into per-channel strobes and fans out sync_clr.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int WIDTH       = CLK_DIV_WIDTH,
  parameter  int DEFAULT_DIV = CLK_DIV_RESET,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  input  logic              wr_now,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] upd_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Selects >= NUM_CH match no channel, so out-of-range writes are dropped.
    logic wr;
    assign wr = wr_en && (wr_ch == CH_W'(i));

    div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sync_clr    (sync_clr),
      .wr          (wr),
      .wr_div      (wr_div),
      .wr_now      (wr_now),
      .tick        (tick[i]),
      .clk_out     (clk_out[i]),
      .upd_pending (upd_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: expected per-cycle outputs are
// queued when stimulus is driven and compared at the falling edge.
module tb_multi_clock_divider;

  localparam int NUM_CH = 5;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 3;

  localparam int K_TICK = 0;
  localparam int K_CLK  = 1;
  localparam int K_PEND = 2;

  logic              clk;
  logic              rst;
  logic              sync_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [WIDTH-1:0]  wr_div;
  logic              wr_now;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] upd_pending;

  multi_clock_divider #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sync_clr    (sync_clr),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_div      (wr_div),
    .wr_now      (wr_now),
    .tick        (tick),
    .clk_out     (clk_out),
    .upd_pending (upd_pending)
  );

  typedef struct {
    int   cyc;
    int   ch;
    int   kind;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Ordered insert keeps the queue sorted by cycle.
  function automatic void push(input int c, input int ch, input int kind, input logic v);
    exp_t e;
    int   idx;
    e.cyc = c; e.ch = ch; e.kind = kind; e.val = v;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t  e;
      logic  got;
      string nm;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check("sb_late", e.cyc, cyc);
      end else begin
        case (e.kind)
          K_TICK:  begin got = tick[e.ch];        nm = "tick";        end
          K_CLK:   begin got = clk_out[e.ch];     nm = "clk_out";     end
          default: begin got = upd_pending[e.ch]; nm = "upd_pending"; end
        endcase
        check($sformatf("%s[%0d]@%0d", nm, e.ch, e.cyc), 32'(got), 32'(e.val));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one write for a single cycle; returns just after the edge that
  // sampled it, so cyc then names the first cycle showing its effect.
  task automatic do_write(input int ch, input int div, input logic now);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = WIDTH'(div);
    wr_now = now;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    wr_now = 1'b0;
  endtask

  initial begin
    int w;
    int s;
    rst = 1'b1; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_now = 1'b0;

    // Reset state
    wait_cycles(2);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_pending", 32'(upd_pending), 32'h0);
    rst = 1'b0;

    // Park channels 1..4 disabled so their clk_out stays at 0.
    for (int c = 1; c < NUM_CH; c++) do_write(c, 0, 1'b1);

    // Test 1: D=4 on ch0, ticks every 4, clk_out period 8.
    do_write(0, 4, 1'b1);
    w = cyc;
    for (int k = 0; k <= 12; k++) begin
      push(w + k, 0, K_TICK, (k > 0) && (k % 4 == 0));
      push(w + k, 0, K_CLK, ((k / 4) % 2) == 1);
      push(w + k, 0, K_PEND, 1'b0);
      push(w + k, 3, K_TICK, 1'b0);
    end
    wait_cycles(13);

    // Test 2: D=5 on ch1, deferred 3 written while count=1.
    do_write(1, 5, 1'b1);
    w = cyc;
    for (int k = 0; k <= 12; k++) begin
      push(w + k, 1, K_TICK, (k == 5) || (k == 8) || (k == 11));
      push(w + k, 1, K_CLK, (k >= 5 && k <= 7) || (k >= 11));
      push(w + k, 1, K_PEND, (k >= 2) && (k <= 4));
    end
    wait_cycles(1);
    do_write(1, 3, 1'b0);
    wait_cycles(12);

    // Test 3: D=8 on ch3, then immediate D=7 while count=5 and clk_out=1.
    do_write(3, 8, 1'b1);
    w = cyc;
    for (int k = 0; k <= 22; k++) begin
      push(w + k, 3, K_TICK, (k == 8) || (k == 21));
      push(w + k, 3, K_CLK, (k >= 8) && (k <= 20));
      push(w + k, 3, K_PEND, 1'b0);
    end
    wait_cycles(13);
    do_write(3, 7, 1'b1);
    wait_cycles(9);

    // Test 4: ch2 raised to clk_out=1, disabled (frozen), then deferred D=2.
    do_write(2, 1, 1'b1);
    w = cyc;
    for (int k = 0; k <= 14; k++) begin
      push(w + k, 2, K_TICK, (k == 1) || (k == 9) || (k == 11) || (k == 13));
      push(w + k, 2, K_CLK, (k >= 1 && k <= 8) || (k == 11) || (k == 12));
      push(w + k, 2, K_PEND, k == 6);
    end
    wait_cycles(1);
    do_write(2, 0, 1'b1);
    wait_cycles(3);
    do_write(2, 2, 1'b0);
    wait_cycles(9);

    // Test 5: D=1 on ch4; writes to wr_ch=NUM_CH must change nothing.
    do_write(4, 1, 1'b1);
    w = cyc;
    for (int k = 0; k <= 10; k++) begin
      push(w + k, 4, K_TICK, k >= 1);
      push(w + k, 4, K_CLK, (k % 2) == 1);
    end
    wait_cycles(2);
    do_write(NUM_CH, 3, 1'b1);
    do_write(NUM_CH, 7, 1'b0);
    check("bad_ch_pending", 32'(upd_pending), 32'h0);
    wait_cycles(7);

    // Test 6: ch1 pending 2 then 6 (last wins), sync_clr with ch3 write of 9.
    do_write(1, 2, 1'b0);
    wr_en = 1'b1; wr_ch = CH_W'(1); wr_div = WIDTH'(6); wr_now = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    sync_clr = 1'b1; wr_ch = CH_W'(3); wr_div = WIDTH'(9);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        for (int c = 0; c < NUM_CH; c++) begin
          push(s + k, c, K_TICK, 1'b0);
          push(s + k, c, K_CLK, 1'b0);
          push(s + k, c, K_PEND, 1'b0);
        end
      end else begin
        push(s + k, 1, K_TICK, k == 7);
        push(s + k, 1, K_CLK, k >= 7);
        push(s + k, 3, K_TICK, k == 10);
        push(s + k, 3, K_CLK, k >= 10);
        push(s + k, 0, K_TICK, (k == 5) || (k == 9));
        push(s + k, 4, K_TICK, 1'b1);
      end
    end
    @(posedge clk); #1;
    sync_clr = 1'b0; wr_en = 1'b0;
    wait_cycles(12);

    // Asynchronous reset mid-cycle with a pending write outstanding.
    do_write(0, 3, 1'b0);
    check("pre_rst_pending", 32'(upd_pending), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_clk_out", 32'(clk_out), 32'h0);
    check("async_rst_pending", 32'(upd_pending), 32'h0);
    #2;
    rst = 1'b0;
    wait_cycles(3);
    check("post_rst_pending", 32'(upd_pending), 32'h0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
